// File: rtl/demux2_buf.sv
// demux2_buf -- registered 1-to-2 demultiplexer with per-sink output registers.
//
// Purpose:
//   Accepts one WL-bit word stream on a valid/ready handshake and steers each
//   word to sink 0 or sink 1 according to DMUX_SEL. Each sink has its own
//   single-entry output register, so a stalled sink only blocks words that
//   target it. Words delivered to each sink are counted modulo 256 for debug.
//
// Ports:
//   CLK        in   1    clock, rising edge
//   RST        in   1    asynchronous active-high reset
//   Din        in   WL   input data word
//   DMUX_SEL   in   1    destination select (0 -> sink 0, 1 -> sink 1)
//   Din_valid  in   1    Din / DMUX_SEL valid
//   Din_ready  out  1    word accepted this cycle when Din_valid is high
//   Dout0      out  WL   sink-0 data register
//   Dout0_vld  out  1    Dout0 holds an undelivered word
//   Dout0_rdy  in   1    sink 0 takes Dout0 this cycle
//   Dout1      out  WL   sink-1 data register
//   Dout1_vld  out  1    Dout1 holds an undelivered word
//   Dout1_rdy  in   1    sink 1 takes Dout1 this cycle
//   Cnt0       out  8    words delivered to sink 0 (mod 256)
//   Cnt1       out  8    words delivered to sink 1 (mod 256)

module demux2_buf #(
  parameter int WL = 32
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [WL-1:0] Din,
  input  logic          DMUX_SEL,
  input  logic          Din_valid,
  output logic          Din_ready,
  output logic [WL-1:0] Dout0,
  output logic          Dout0_vld,
  input  logic          Dout0_rdy,
  output logic [WL-1:0] Dout1,
  output logic          Dout1_vld,
  input  logic          Dout1_rdy,
  output logic [7:0]    Cnt0,
  output logic [7:0]    Cnt1
);

  logic [WL-1:0] dout0_r, dout1_r;
  logic          vld0_r, vld1_r;
  logic [7:0]    cnt0_r, cnt1_r;

  logic          ready_s;
  logic          acc_s;
  logic          load0_s, load1_s;
  logic          xfer0_s, xfer1_s;
  logic [WL-1:0] dout0_nxt_s, dout1_nxt_s;
  logic          vld0_nxt_s, vld1_nxt_s;
  logic [7:0]    cnt0_nxt_s, cnt1_nxt_s;

  // Handshake decode: a channel can take a new word when empty or when it is
  // draining this same cycle, which allows one word per cycle per channel.
  always_comb begin
    xfer0_s = vld0_r & Dout0_rdy;
    xfer1_s = vld1_r & Dout1_rdy;
    if (DMUX_SEL == 1'b1) begin
      ready_s = ~vld1_r | Dout1_rdy;
    end else begin
      ready_s = ~vld0_r | Dout0_rdy;
    end
    acc_s   = Din_valid & ready_s;
    load0_s = acc_s & ~DMUX_SEL;
    load1_s = acc_s & DMUX_SEL;
  end

  // Next-state for channel 0: a load wins over a drain so that a simultaneous
  // deliver+load keeps the valid flag set with the fresh word.
  always_comb begin
    dout0_nxt_s = dout0_r;
    vld0_nxt_s  = vld0_r;
    cnt0_nxt_s  = cnt0_r;
    if (load0_s) begin
      dout0_nxt_s = Din;
      vld0_nxt_s  = 1'b1;
    end else if (xfer0_s) begin
      vld0_nxt_s  = 1'b0;
    end else begin
      vld0_nxt_s  = vld0_r;
    end
    if (xfer0_s) begin
      cnt0_nxt_s = cnt0_r + 8'd1;
    end else begin
      cnt0_nxt_s = cnt0_r;
    end
  end

  // Next-state for channel 1, mirror of channel 0.
  always_comb begin
    dout1_nxt_s = dout1_r;
    vld1_nxt_s  = vld1_r;
    cnt1_nxt_s  = cnt1_r;
    if (load1_s) begin
      dout1_nxt_s = Din;
      vld1_nxt_s  = 1'b1;
    end else if (xfer1_s) begin
      vld1_nxt_s  = 1'b0;
    end else begin
      vld1_nxt_s  = vld1_r;
    end
    if (xfer1_s) begin
      cnt1_nxt_s = cnt1_r + 8'd1;
    end else begin
      cnt1_nxt_s = cnt1_r;
    end
  end

  // State registers; reset drops any word in flight.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dout0_r <= {WL{1'b0}};
      dout1_r <= {WL{1'b0}};
      vld0_r  <= 1'b0;
      vld1_r  <= 1'b0;
      cnt0_r  <= 8'd0;
      cnt1_r  <= 8'd0;
    end else begin
      dout0_r <= dout0_nxt_s;
      dout1_r <= dout1_nxt_s;
      vld0_r  <= vld0_nxt_s;
      vld1_r  <= vld1_nxt_s;
      cnt0_r  <= cnt0_nxt_s;
      cnt1_r  <= cnt1_nxt_s;
    end
  end

  assign Din_ready = ready_s;
  assign Dout0     = dout0_r;
  assign Dout0_vld = vld0_r;
  assign Dout1     = dout1_r;
  assign Dout1_vld = vld1_r;
  assign Cnt0      = cnt0_r;
  assign Cnt1      = cnt1_r;

endmodule

// File: tb/tb_demux2_buf.sv
// tb_demux2_buf -- self-checking bench for demux2_buf.
//
// Purpose:
//   Drives directed scenarios (reset, single steer, backpressure, channel
//   independence, throughput, counter wrap). A small reference model tracks
//   per-channel valid/data/count and the expected Din_ready; a scoreboard
//   queue per channel holds accepted words and is popped whenever the DUT
//   delivers a word to that sink.

module tb_demux2_buf;

  logic        CLK;
  logic        RST;
  logic [31:0] Din;
  logic        DMUX_SEL;
  logic        Din_valid;
  logic        Din_ready;
  logic [31:0] Dout0;
  logic        Dout0_vld;
  logic        Dout0_rdy;
  logic [31:0] Dout1;
  logic        Dout1_vld;
  logic        Dout1_rdy;
  logic [7:0]  Cnt0;
  logic [7:0]  Cnt1;

  demux2_buf #(.WL(32)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .Din       (Din),
    .DMUX_SEL  (DMUX_SEL),
    .Din_valid (Din_valid),
    .Din_ready (Din_ready),
    .Dout0     (Dout0),
    .Dout0_vld (Dout0_vld),
    .Dout0_rdy (Dout0_rdy),
    .Dout1     (Dout1),
    .Dout1_vld (Dout1_vld),
    .Dout1_rdy (Dout1_rdy),
    .Cnt0      (Cnt0),
    .Cnt1      (Cnt1)
  );

  // Free-running clock, period 10.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int checks_cnt   = 0;
  int failures_cnt = 0;

  // Reference model state.
  logic        m_v0, m_v1;
  logic [31:0] m_d0, m_d1;
  logic [7:0]  m_c0, m_c1;
  logic [31:0] q0[$];
  logic [31:0] q1[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      failures_cnt++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_v0 = 1'b0; m_v1 = 1'b0;
    m_d0 = 32'd0; m_d1 = 32'd0;
    m_c0 = 8'd0; m_c1 = 8'd0;
    q0.delete();
    q1.delete();
  endtask

  // One clock cycle: drive inputs (we sit just after a falling edge), compare
  // DUT against the model, run the scoreboard, then advance model and clock.
  task automatic step(input logic v, input logic s, input logic [31:0] d,
                      input logic r0, input logic r1);
    logic m_rdy, m_acc, x0, x1;
    Din_valid = v; DMUX_SEL = s; Din = d; Dout0_rdy = r0; Dout1_rdy = r1;
    #1;
    m_rdy = s ? (!m_v1 || r1) : (!m_v0 || r0);
    m_acc = v && m_rdy;
    x0 = m_v0 && r0;
    x1 = m_v1 && r1;
    check_eq("din_ready", {31'd0, Din_ready}, {31'd0, m_rdy});
    check_eq("vld0", {31'd0, Dout0_vld}, {31'd0, m_v0});
    check_eq("vld1", {31'd0, Dout1_vld}, {31'd0, m_v1});
    check_eq("cnt0", {24'd0, Cnt0}, {24'd0, m_c0});
    check_eq("cnt1", {24'd0, Cnt1}, {24'd0, m_c1});
    if (m_v0) check_eq("dout0", Dout0, m_d0);
    if (m_v1) check_eq("dout1", Dout1, m_d1);
    // Scoreboard: pop on delivery (before push, so deliver+load works).
    if (Dout0_vld && r0) begin
      if (q0.size() == 0) check_eq("sb0_extra", {31'd0, Dout0_vld}, 32'd0);
      else check_eq("sb0_data", Dout0, q0.pop_front());
    end
    if (Dout1_vld && r1) begin
      if (q1.size() == 0) check_eq("sb1_extra", {31'd0, Dout1_vld}, 32'd0);
      else check_eq("sb1_data", Dout1, q1.pop_front());
    end
    if (m_acc && !s) q0.push_back(d);
    if (m_acc && s)  q1.push_back(d);
    // Model update.
    if (x0) m_c0 = m_c0 + 8'd1;
    if (x1) m_c1 = m_c1 + 8'd1;
    if (m_acc && !s) begin m_d0 = d; m_v0 = 1'b1; end
    else if (x0) m_v0 = 1'b0;
    if (m_acc && s) begin m_d1 = d; m_v1 = 1'b1; end
    else if (x1) m_v1 = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Asynchronous mid-cycle reset; outputs must clear before the next edge.
  task automatic do_reset(input string tag);
    Din_valid = 1'b0; DMUX_SEL = 1'b0; Din = 32'd0; Dout0_rdy = 1'b0; Dout1_rdy = 1'b0;
    #2 RST = 1'b1;
    #1;
    check_eq({tag, "_dout0"}, Dout0, 32'd0);
    check_eq({tag, "_dout1"}, Dout1, 32'd0);
    check_eq({tag, "_vld0"}, {31'd0, Dout0_vld}, 32'd0);
    check_eq({tag, "_vld1"}, {31'd0, Dout1_vld}, 32'd0);
    check_eq({tag, "_cnt0"}, {24'd0, Cnt0}, 32'd0);
    check_eq({tag, "_cnt1"}, {24'd0, Cnt1}, 32'd0);
    model_clear();
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    Din = 32'd0; DMUX_SEL = 1'b0; Din_valid = 1'b0;
    Dout0_rdy = 1'b0; Dout1_rdy = 1'b0;
    model_clear();
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;

    // Single steer to sink 1, then deliver.
    step(1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    check_eq("t2_dout1", Dout1, 32'hDEADBEEF);
    check_eq("t2_vld1", {31'd0, Dout1_vld}, 32'd1);
    check_eq("t2_vld0", {31'd0, Dout0_vld}, 32'd0);
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    check_eq("t2_vld1_drop", {31'd0, Dout1_vld}, 32'd0);
    check_eq("t2_cnt1", {24'd0, Cnt1}, 32'd1);

    // Backpressure on sink 0 for 5 cycles, then release.
    step(1'b1, 1'b0, 32'h1111_0000, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 32'h2222_0000, 1'b0, 1'b0);
      check_eq("t3_stall_ready", {31'd0, Din_ready}, 32'd0);
      check_eq("t3_stall_dout0", Dout0, 32'h1111_0000);
    end
    Din_valid = 1'b1; Dout0_rdy = 1'b1;
    #1 check_eq("t3_release_ready", {31'd0, Din_ready}, 32'd1);
    step(1'b1, 1'b0, 32'h2222_0000, 1'b1, 1'b0);
    check_eq("t3_new_word", Dout0, 32'h2222_0000);
    check_eq("t3_new_vld", {31'd0, Dout0_vld}, 32'd1);

    // Reset with both channels holding words.
    step(1'b1, 1'b1, 32'hB0B0_B0B0, 1'b0, 1'b0);
    check_eq("t1_pre_vld0", {31'd0, Dout0_vld}, 32'd1);
    check_eq("t1_pre_vld1", {31'd0, Dout1_vld}, 32'd1);
    do_reset("t1_rst");

    // Independence: sink 0 stalled, 4 words stream to sink 1.
    step(1'b1, 1'b0, 32'hC0C0_0001, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 32'hA000_0000 + i, 1'b0, 1'b1);
    end
    step(1'b0, 1'b1, 32'd0, 1'b0, 1'b1);
    check_eq("t4_cnt1", {24'd0, Cnt1}, 32'd4);
    check_eq("t4_cnt0", {24'd0, Cnt0}, 32'd0);
    check_eq("t4_dout0", Dout0, 32'hC0C0_0001);
    check_eq("t4_q1_empty", q1.size(), 32'd0);
    do_reset("t4_rst");

    // Throughput: 10 back-to-back words to sink 0.
    for (int i = 0; i < 10; i++) begin
      Din_valid = 1'b1; DMUX_SEL = 1'b0; Dout0_rdy = 1'b1;
      #1 check_eq("t5_ready", {31'd0, Din_ready}, 32'd1);
      step(1'b1, 1'b0, 32'h5000_0000 + i, 1'b1, 1'b0);
    end
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    check_eq("t5_cnt0", {24'd0, Cnt0}, 32'd10);
    do_reset("t5_rst");

    // Wrap: 257 transfers on sink 1.
    for (int i = 0; i < 257; i++) begin
      step(1'b1, 1'b1, 32'h6000_0000 + i, 1'b0, 1'b1);
    end
    step(1'b0, 1'b1, 32'd0, 1'b0, 1'b1);
    check_eq("t6_cnt1", {24'd0, Cnt1}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, failures_cnt);
    $finish;
  end

endmodule
